// File: rtl/l2_req_arb.sv
// Round-robin arbiter sharing one OpenCAPI request channel among stream-pointer requesters,
// with tagged response demux. Define L2_REQ_ARB_CREDIT_EN to enable the in-flight credit limit.
module l2_req_arb #(
    parameter int unsigned n_streams       = 8,
    parameter int unsigned tag_width       = $clog2(n_streams),
    parameter int unsigned max_outstanding = 16,
    parameter int unsigned cnt_width       = $clog2(max_outstanding + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [n_streams-1:0] i_req_v,
    output logic [n_streams-1:0] i_req_r,
    output logic                 o_req_v,
    input  logic                 o_req_r,
    output logic [tag_width-1:0] o_req_tag,
    input  logic                 i_rsp_v,
    output logic                 i_rsp_r,
    input  logic [tag_width-1:0] i_rsp_tag,
    output logic [n_streams-1:0] o_rsp_v,
    input  logic [n_streams-1:0] o_rsp_r,
    output logic [cnt_width-1:0] o_outstanding,
    output logic                 o_err
);

    logic                 r_req_v;
    logic [tag_width-1:0] r_req_tag;
    logic [tag_width-1:0] r_last;
    logic                 r_err;

    logic [tag_width-1:0] w_winner;
    logic [tag_width-1:0] w_idx;
    logic                 w_found;
    logic                 w_can_load;
    logic                 w_credit;
    logic                 w_grant;
    logic [n_streams-1:0] w_req_r;
    logic                 w_bad_tag;
    logic                 w_rsp_r;
    logic [n_streams-1:0] w_rsp_v;
    logic                 w_rsp_hs;
    logic                 w_underflow;

    // Search starts one past the last winner and wraps, giving round-robin fairness.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        w_idx    = '0;
        for (int i = 1; i <= int'(n_streams); i++) begin
            w_idx = tag_width'((int'(r_last) + i) % int'(n_streams));
            if (!w_found && i_req_v[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_can_load = !r_req_v || o_req_r;
    assign w_grant    = !reset && w_can_load && w_credit && w_found;

    always_comb begin
        w_req_r = '0;
        if (w_grant) begin
            w_req_r[w_winner] = 1'b1;
        end
    end

    assign w_bad_tag = int'(i_rsp_tag) >= int'(n_streams);

    // Out-of-range tags are always accepted so a bad response cannot wedge the channel.
    always_comb begin
        w_rsp_r = 1'b0;
        if (!reset) begin
            if (w_bad_tag) begin
                w_rsp_r = 1'b1;
            end else begin
                w_rsp_r = o_rsp_r[i_rsp_tag];
            end
        end
    end

    always_comb begin
        w_rsp_v = '0;
        for (int k = 0; k < int'(n_streams); k++) begin
            w_rsp_v[k] = !reset && i_rsp_v && (i_rsp_tag == tag_width'(k));
        end
    end

    assign w_rsp_hs = i_rsp_v && w_rsp_r;

`ifdef L2_REQ_ARB_CREDIT_EN
    localparam int unsigned CntW1 = cnt_width + 1;

    logic [cnt_width-1:0] r_outstanding;
    logic [CntW1-1:0]     w_inflight;
    logic                 w_inc;
    logic                 w_dec;

    // The staged request already holds a credit even before it is accepted downstream.
    assign w_inflight  = CntW1'(r_outstanding) + CntW1'(r_req_v);
    assign w_credit    = w_inflight < CntW1'(max_outstanding);
    assign w_inc       = r_req_v && o_req_r;
    assign w_dec       = w_rsp_hs;
    assign w_underflow = w_dec && !w_inc && (r_outstanding == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
        end else if (w_inc && !w_dec) begin
            r_outstanding <= r_outstanding + cnt_width'(1);
        end else if (w_dec && !w_inc && !w_underflow) begin
            r_outstanding <= r_outstanding - cnt_width'(1);
        end
    end

    assign o_outstanding = r_outstanding;
`else
    assign w_credit      = 1'b1;
    assign w_underflow   = 1'b0;
    assign o_outstanding = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_v   <= 1'b0;
            r_req_tag <= '0;
            r_last    <= tag_width'(n_streams - 1);
            r_err     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_req_v   <= 1'b1;
                r_req_tag <= w_winner;
                r_last    <= w_winner;
            end else if (o_req_r) begin
                r_req_v <= 1'b0;
            end
            r_err <= r_err || (w_rsp_hs && w_bad_tag) || w_underflow;
        end
    end

    assign i_req_r   = w_req_r;
    assign o_req_v   = r_req_v;
    assign o_req_tag = r_req_tag;
    assign i_rsp_r   = w_rsp_r;
    assign o_rsp_v   = w_rsp_v;
    assign o_err     = r_err;

endmodule
